sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like bus (req/addr_ok/data_ok) between the instruction-fetch port and the data port of the pipeline.
- The data port is the one driven by EX and consumed by the MEM stage through data_sram_rdata/data_sram_dataok.
- Arbitrates address phases, holds a granted request until it is accepted, and records the source of every accepted transaction in an in-order ID FIFO, so each bus data_ok/rdata is routed back to the correct requester.
- Sits between the core and the AXI bridge.

---
 rtl/sram_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the fetch port and the
// data port, and routes in-order returns back through an ID FIFO.
// Optional build macro: ARB_RR_EN selects round-robin arbitration in IDLE
// (default build: fixed data priority).
module sram_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic [2:0]  data_outstanding,
  output logic        orphan_err
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;

  state_e                     state_q;
  logic [MAX_OUTSTANDING-1:0] id_mem_q;
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              dout_q, dout_d;
  logic                       orphan_q;
`ifdef ARB_RR_EN
  logic                       last_grant_q;   // 0 = inst, 1 = data
`endif

  logic gnt_data, gnt_inst, gnt_req;
  logic full, push, pop, head_id;

  // Grant selection: locked in HOLD states, arbitrated in IDLE
  always_comb begin
    gnt_data = 1'b0;
    gnt_inst = 1'b0;
    case (state_q)
      HOLD_I: gnt_inst = 1'b1;
      HOLD_D: gnt_data = 1'b1;
      default: begin
`ifdef ARB_RR_EN
        if (data_req && inst_req) begin
          gnt_data = ~last_grant_q;
          gnt_inst = last_grant_q;
        end else begin
          gnt_data = data_req;
          gnt_inst = inst_req;
        end
`else
        gnt_data = data_req;
        gnt_inst = ~data_req & inst_req;
`endif
      end
    endcase
  end

  assign gnt_req = (gnt_data & data_req) | (gnt_inst & inst_req);
  assign full    = (cnt_q == CW'(MAX_OUTSTANDING));
  assign bus_req = ~reset & gnt_req & ~full;
  assign push    = bus_req & bus_addr_ok;
  assign pop     = ~reset & bus_data_ok & (cnt_q != '0);
  assign head_id = id_mem_q[rptr_q];

  assign inst_addr_ok = push & gnt_inst;
  assign data_addr_ok = push & gnt_data;
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = reset ? 32'h0 : bus_rdata;
  assign data_rdata   = reset ? 32'h0 : bus_rdata;

  assign data_outstanding = reset ? 3'd0 : 3'(dout_q);
  assign orphan_err       = orphan_q & ~reset;

  // Bus payload mux of the granted source; zero when nothing is granted
  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'h0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    if (!reset && gnt_data) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else if (!reset && gnt_inst) begin
      bus_size  = 2'd2;
      bus_addr  = inst_addr;
    end
  end

  // Grant lock state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:           if (bus_req && !bus_addr_ok) state_q <= gnt_data ? HOLD_D : HOLD_I;
        HOLD_I, HOLD_D: if (push || !gnt_req)        state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

  // Occupancy and data-outstanding next values
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
    if ((push && gnt_data) && !(pop && head_id))      dout_d = dout_q + CW'(1);
    else if (!(push && gnt_data) && (pop && head_id)) dout_d = dout_q - CW'(1);
  end

  // ID FIFO, counters and sticky orphan flag
  always_ff @(posedge clk) begin
    if (reset) begin
      id_mem_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (push) begin
        id_mem_q[wptr_q] <= gnt_data;
        wptr_q           <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      if (bus_data_ok && cnt_q == '0) orphan_q <= 1'b1;
    end
  end

`ifdef ARB_RR_EN
  // Remember the last accepted source for round-robin
  always_ff @(posedge clk) begin
    if (reset)     last_grant_q <= 1'b0;
    else if (push) last_grant_q <= gnt_data;
  end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  data_outstanding;
  logic        orphan_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .data_outstanding(data_outstanding), .orphan_err(orphan_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  initial begin
    logic exp_d;
    logic [3:0] seq4;

    // Reset: outputs stay zero even with live inputs
    reset = 1; clear_in();
    step(); step();
    inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1; bus_data_ok = 1;
    settle();
    check("rst_bus_req", bus_req, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_orphan", orphan_err, 0);
    check("rst_dout", data_outstanding, 0);
    step(); reset = 0; clear_in(); settle();
    check("idle_bus_req", bus_req, 0);
    check("idle_orphan", orphan_err, 0);

    // Single fetch, data back two cycles later
    inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1; settle();
    check("f_bus_req", bus_req, 1);
    check("f_bus_addr", bus_addr, 32'hBFC00000);
    check("f_bus_size", bus_size, 2);
    check("f_bus_wr", bus_wr, 0);
    check("f_inst_addr_ok", inst_addr_ok, 1);
    check("f_data_addr_ok", data_addr_ok, 0);
    step(); inst_req = 0; bus_addr_ok = 0; settle();
    check("f1_inst_data_ok", inst_data_ok, 0);
    check("f1_data_data_ok", data_data_ok, 0);
    step(); bus_data_ok = 1; bus_rdata = 32'h3C080001; settle();
    check("f2_inst_data_ok", inst_data_ok, 1);
    check("f2_inst_rdata", inst_rdata, 32'h3C080001);
    check("f2_data_data_ok", data_data_ok, 0);
    step(); clear_in(); settle();
    check("f3_inst_data_ok", inst_data_ok, 0);

    // Both request; data store held for three cycles, then inst
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h80001004; data_wdata = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      bus_addr_ok = (c == 3); settle();
      check("hd_bus_addr", bus_addr, 32'h80001004);
      check("hd_bus_wr", bus_wr, 1);
      check("hd_data_addr_ok", data_addr_ok, (c == 3));
      check("hd_inst_addr_ok", inst_addr_ok, 0);
      if (c == 3) begin
        check("hd_wstrb", bus_wstrb, 4'hF);
        check("hd_wdata", bus_wdata, 32'h12345678);
      end
      step();
    end
    data_req = 0; bus_addr_ok = 1; settle();
    check("hd_inst_addr", bus_addr, 32'hBFC00004);
    check("hd_inst_addr_ok", inst_addr_ok, 1);
    check("hd_inst_wstrb", bus_wstrb, 0);
    check("hd_inst_wdata", bus_wdata, 0);
    check("hd_dout1", data_outstanding, 1);
    step(); inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; settle();
    check("hd_ret_d", data_data_ok, 1);
    check("hd_ret_d_i", inst_data_ok, 0);
    step(); bus_rdata = 32'h11112222; settle();
    check("hd_ret_i", inst_data_ok, 1);
    check("hd_ret_i_rdata", inst_rdata, 32'h11112222);
    check("hd_dout0", data_outstanding, 0);
    step(); clear_in();

    // Inst locked while data arrives
    inst_req = 1; inst_addr = 32'hBFC00008; settle();
    check("lk_bus_addr0", bus_addr, 32'hBFC00008);
    step();
    data_req = 1; data_addr = 32'h80002000; data_size = 0; settle();
    check("lk_bus_addr1", bus_addr, 32'hBFC00008);
    check("lk_data_addr_ok1", data_addr_ok, 0);
    step(); bus_addr_ok = 1; settle();
    check("lk_inst_addr_ok", inst_addr_ok, 1);
    check("lk_data_addr_ok2", data_addr_ok, 0);
    step(); inst_req = 0; settle();
    check("lk_bus_addr3", bus_addr, 32'h80002000);
    check("lk_bus_size3", bus_size, 0);
    check("lk_data_addr_ok3", data_addr_ok, 1);
    step(); data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; settle();
    check("lk_ret_i", inst_data_ok, 1);
    step(); settle();
    check("lk_ret_d", data_data_ok, 1);
    step(); clear_in();

    // Fill the FIFO with D, I, D, D
    seq4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      exp_d = seq4[i];
      data_req = exp_d; inst_req = !exp_d;
      data_addr = 32'h80003000 + 32'(i * 4); inst_addr = 32'hBFC00100 + 32'(i * 4);
      bus_addr_ok = 1; settle();
      check("fill_data_addr_ok", data_addr_ok, exp_d);
      check("fill_inst_addr_ok", inst_addr_ok, !exp_d);
      step();
    end
    inst_req = 0; data_req = 1; data_addr = 32'h80003010; bus_addr_ok = 1; settle();
    check("full_bus_req", bus_req, 0);
    check("full_data_addr_ok", data_addr_ok, 0);
    check("full_dout", data_outstanding, 3);
    step(); bus_data_ok = 1; settle();
    check("full_pop_bus_req", bus_req, 0);
    check("full_pop_data_ok", data_data_ok, 1);
    check("full_pop_inst_ok", inst_data_ok, 0);
    step(); bus_data_ok = 0; settle();
    check("after_pop_bus_req", bus_req, 1);
    check("after_pop_addr_ok", data_addr_ok, 1);
    check("after_pop_dout", data_outstanding, 2);
    step(); data_req = 0; bus_addr_ok = 0; settle();
    check("refill_dout", data_outstanding, 3);
    seq4 = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      exp_d = seq4[i];
      bus_data_ok = 1; settle();
      check("drain_data_ok", data_data_ok, exp_d);
      check("drain_inst_ok", inst_data_ok, !exp_d);
      step();
    end
    bus_data_ok = 0; settle();
    check("drain_dout", data_outstanding, 0);
    check("drain_orphan", orphan_err, 0);

    // Ten single transactions walk the pointers around several times
    for (int i = 0; i < 10; i++) begin
      exp_d = (i % 3) != 0;
      data_req = exp_d; inst_req = !exp_d; bus_addr_ok = 1; settle();
      check("wrap_addr_ok", exp_d ? data_addr_ok : inst_addr_ok, 1);
      step();
      data_req = 0; inst_req = 0; bus_addr_ok = 0;
      bus_data_ok = 1; bus_rdata = 32'h01010101 * 32'(i); settle();
      check("wrap_data_ok", data_data_ok, exp_d);
      check("wrap_inst_ok", inst_data_ok, !exp_d);
      check("wrap_rdata", exp_d ? data_rdata : inst_rdata, 32'h01010101 * 32'(i));
      step(); bus_data_ok = 0;
    end
    clear_in(); settle();
    check("wrap_dout", data_outstanding, 0);

    // Orphan return with an empty FIFO
    bus_data_ok = 1; bus_rdata = 32'hDEADBEEF; settle();
    check("orph_data_ok", data_data_ok, 0);
    check("orph_inst_ok", inst_data_ok, 0);
    step(); bus_data_ok = 0; settle();
    check("orph_set", orphan_err, 1);
    step();
    check("orph_held", orphan_err, 1);

    // Reset in the middle of HOLD_D
    data_req = 1; data_addr = 32'h80004000; bus_addr_ok = 1; settle();
    step(); bus_addr_ok = 0; data_addr = 32'h80004004; settle();
    check("hdr_dout1", data_outstanding, 1);
    step(); inst_req = 1; inst_addr = 32'hBFC00200; settle();
    check("hdr_locked", bus_addr, 32'h80004004);
    reset = 1; settle();
    check("hdr_rst_bus_req", bus_req, 0);
    check("hdr_rst_dout", data_outstanding, 0);
    check("hdr_rst_orphan", orphan_err, 0);
    step(); reset = 0; data_req = 0; settle();
    check("hdr_idle_addr", bus_addr, 32'hBFC00200);
    check("hdr_orphan", orphan_err, 0);
    check("hdr_dout", data_outstanding, 0);
    clear_in(); bus_data_ok = 1; settle();
    check("hdr_late_data_ok", data_data_ok, 0);
    step(); bus_data_ok = 0; settle();
    check("hdr_late_orphan", orphan_err, 1);

    // Both held with immediate accept
    reset = 1; step(); reset = 0; settle();
    inst_req = 1; inst_addr = 32'hBFC00300;
    data_req = 1; data_addr = 32'h80005000; bus_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
`ifdef ARB_RR_EN
      check("arb_addr", bus_addr, (c % 2 == 0) ? 32'h80005000 : 32'hBFC00300);
`else
      check("arb_addr", bus_addr, 32'h80005000);
`endif
      step();
    end
    clear_in(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
